// File: rtl/alu_issue_stage.sv
// ALU issue stage: single register slot between decode and the ALU.
// Forwards rs1/rs2 from EX/WB at capture time, then selects the ALU operands.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_ALUAsrc,
    input  logic [1:0]  in_ALUBsrc,
    input  logic [3:0]  in_ALUctr,
    input  logic        in_regwr,
    input  logic        ex_fwd_valid,
    input  logic [4:0]  ex_fwd_rd,
    input  logic [31:0] ex_fwd_data,
    input  logic        wb_fwd_valid,
    input  logic [4:0]  wb_fwd_rd,
    input  logic [31:0] wb_fwd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dataa,
    output logic [31:0] datab,
    output logic [3:0]  ALUctr,
    output logic [31:0] out_store_data,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        out_regwr
);

    logic [1:0][4:0]  src_idx;
    logic [1:0][31:0] src_data;
    logic [1:0][31:0] fwd_val;

    logic        valid_reg;
    logic [31:0] dataa_reg;
    logic [31:0] datab_reg;
    logic [3:0]  ctr_reg;
    logic [31:0] store_reg;
    logic [31:0] pc_reg;
    logic [4:0]  rd_reg;
    logic        regwr_reg;

    logic [31:0] datab_next;
    logic        load;

    assign src_idx[0]  = in_rs1;
    assign src_idx[1]  = in_rs2;
    assign src_data[0] = in_rs1_data;
    assign src_data[1] = in_rs2_data;

    // x0 is hardwired to zero; EX is the younger producer so it wins over WB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] =
                (src_idx[gi] == 5'd0)                            ? 32'h0 :
                (ex_fwd_valid && (ex_fwd_rd == src_idx[gi]))     ? ex_fwd_data :
                (wb_fwd_valid && (wb_fwd_rd == src_idx[gi]))     ? wb_fwd_data :
                                                                   src_data[gi];
        end
    endgenerate

    always_comb begin
        datab_next = fwd_val[1];
        case (in_ALUBsrc)
            2'b00:   datab_next = fwd_val[1];
            2'b01:   datab_next = in_imm;
            2'b10:   datab_next = 32'd4;
            default: datab_next = 32'd0;
        endcase
    end

    assign in_ready = ~valid_reg | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            dataa_reg <= 32'h0;
            datab_reg <= 32'h0;
            ctr_reg   <= 4'h0;
            store_reg <= 32'h0;
            pc_reg    <= 32'h0;
            rd_reg    <= 5'h0;
            regwr_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            dataa_reg <= in_ALUAsrc ? in_pc : fwd_val[0];
            datab_reg <= datab_next;
            ctr_reg   <= in_ALUctr;
            store_reg <= fwd_val[1];
            pc_reg    <= in_pc;
            rd_reg    <= in_rd;
            regwr_reg <= in_regwr;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid      = valid_reg;
    assign dataa          = dataa_reg;
    assign datab          = datab_reg;
    assign ALUctr         = ctr_reg;
    assign out_store_data = store_reg;
    assign out_pc         = pc_reg;
    assign out_rd         = rd_reg;
    assign out_regwr      = regwr_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: one task per scenario, inline checks.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_ALUAsrc;
    logic [1:0]  in_ALUBsrc;
    logic [3:0]  in_ALUctr;
    logic        in_regwr;
    logic        ex_fwd_valid, wb_fwd_valid;
    logic [4:0]  ex_fwd_rd, wb_fwd_rd;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dataa, datab, out_store_data, out_pc;
    logic [3:0]  ALUctr;
    logic [4:0]  out_rd;
    logic        out_regwr;

    int total = 0;
    int bad   = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_ALUAsrc(in_ALUAsrc), .in_ALUBsrc(in_ALUBsrc), .in_ALUctr(in_ALUctr),
        .in_regwr(in_regwr),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .dataa(dataa), .datab(datab), .ALUctr(ALUctr),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd),
        .out_regwr(out_regwr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] rs1d, input logic [31:0] rs2d,
                            input logic [31:0] imm, input logic asrc,
                            input logic [1:0] bsrc, input logic [3:0] ctr,
                            input logic regwr);
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_data = rs1d; in_rs2_data = rs2d; in_imm = imm;
        in_ALUAsrc = asrc; in_ALUBsrc = bsrc; in_ALUctr = ctr; in_regwr = regwr;
    endtask

    task automatic clear_fwd();
        ex_fwd_valid = 1'b0; ex_fwd_rd = 5'd0; ex_fwd_data = 32'h0;
        wb_fwd_valid = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        drive_op(32'h40, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 2'b00, 4'h5, 1'b1);
        tick(); tick();
        total++;
        if ({out_valid, out_regwr} !== 2'b00) begin
            bad++; $display("FAIL reset_valid got=%b%b exp=00", out_valid, out_regwr);
        end
        total++;
        if ({dataa, datab, out_store_data, out_pc} !== 128'h0) begin
            bad++; $display("FAIL reset_data got=%h %h %h %h exp=0", dataa, datab, out_store_data, out_pc);
        end
        total++;
        if ({out_rd, ALUctr} !== 9'h0) begin
            bad++; $display("FAIL reset_rd_ctr got=%h %h exp=0", out_rd, ALUctr);
        end
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b valid=%b exp=1/0", in_ready, out_valid);
        end
        $display("test_reset: done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_op(32'h1000 + 32'(4 * i), 5'd1, 5'd2, 5'(i + 1), 32'(10 + i), 32'h0,
                     32'(100 + i), 1'b0, 2'b01, 4'(i), 1'b1);
            in_valid = 1'b1;
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_valid op=%0d got=%b/%b exp=1/1", i, out_valid, in_ready);
            end
            total++;
            if (dataa !== 32'(10 + i) || datab !== 32'(100 + i) || ALUctr !== 4'(i)) begin
                bad++; $display("FAIL b2b_data op=%0d got=%h %h %h exp=%h %h %h", i, dataa, datab, ALUctr,
                                32'(10 + i), 32'(100 + i), 4'(i));
            end
            total++;
            if (out_rd !== 5'(i + 1) || out_pc !== 32'h1000 + 32'(4 * i) || out_regwr !== 1'b1) begin
                bad++; $display("FAIL b2b_side op=%0d got=%h %h %b", i, out_rd, out_pc, out_regwr);
            end
            $display("b2b op=%0d dataa=%h datab=%h", i, dataa, datab);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_operand_mux();
        out_ready = 1'b1; in_valid = 1'b1;
        drive_op(32'h200, 5'd4, 5'd6, 5'd7, 32'h1, 32'h66, 32'h99, 1'b0, 2'b10, 4'h1, 1'b0);
        tick();
        total++;
        if (datab !== 32'd4 || out_store_data !== 32'h66 || out_regwr !== 1'b0) begin
            bad++; $display("FAIL mux_const4 got=%h %h %b exp=4 66 0", datab, out_store_data, out_regwr);
        end
        drive_op(32'h204, 5'd4, 5'd6, 5'd7, 32'h1, 32'h67, 32'h99, 1'b0, 2'b11, 4'h2, 1'b1);
        tick();
        total++;
        if (datab !== 32'd0 || out_store_data !== 32'h67) begin
            bad++; $display("FAIL mux_const0 got=%h %h exp=0 67", datab, out_store_data);
        end
        drive_op(32'h208, 5'd4, 5'd6, 5'd7, 32'h1, 32'h68, 32'h99, 1'b0, 2'b00, 4'h3, 1'b1);
        tick();
        total++;
        if (datab !== 32'h68 || dataa !== 32'h1) begin
            bad++; $display("FAIL mux_rs2 got=%h %h exp=68 1", datab, dataa);
        end
        in_valid = 1'b0;
        tick();
        $display("test_operand_mux: done");
    endtask

    task automatic test_stall();
        out_ready = 1'b1; in_valid = 1'b1;
        drive_op(32'h300, 5'd1, 5'd2, 5'd8, 32'd5, 32'h0, 32'd7, 1'b0, 2'b01, 4'h4, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b1 || dataa !== 32'd5 || datab !== 32'd7) begin
            bad++; $display("FAIL stall_load got=%b %h %h exp=1 5 7", out_valid, dataa, datab);
        end
        out_ready = 1'b0;
        drive_op(32'h304, 5'd1, 5'd2, 5'd9, 32'd9, 32'h0, 32'd11, 1'b0, 2'b01, 4'h6, 1'b1);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd1; ex_fwd_data = 32'hDEAD;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL stall_ready got=%b exp=0", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dataa !== 32'd5 || datab !== 32'd7 ||
                ALUctr !== 4'h4 || out_rd !== 5'd8) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b %b %h %h %h %h", c, out_valid, in_ready,
                                dataa, datab, ALUctr, out_rd);
            end
            $display("stall cyc=%0d dataa=%h datab=%h", c, dataa, datab);
        end
        clear_fwd();
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release_ready got=%b exp=1", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || dataa !== 32'd9 || datab !== 32'd11 || out_rd !== 5'd9) begin
            bad++; $display("FAIL stall_next got=%b %h %h %h exp=1 9 b 9", out_valid, dataa, datab, out_rd);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_fwd_priority();
        out_ready = 1'b1; in_valid = 1'b1;
        drive_op(32'h400, 5'd3, 5'd2, 5'd1, 32'd1, 32'h2, 32'h0, 1'b0, 2'b00, 4'h0, 1'b1);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'hAAAA;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hBBBB;
        tick();
        total++;
        if (dataa !== 32'hAAAA) begin
            bad++; $display("FAIL fwd_ex got=%h exp=0000aaaa", dataa);
        end
        ex_fwd_valid = 1'b0;
        tick();
        total++;
        if (dataa !== 32'hBBBB) begin
            bad++; $display("FAIL fwd_wb got=%h exp=0000bbbb", dataa);
        end
        wb_fwd_valid = 1'b0;
        tick();
        total++;
        if (dataa !== 32'd1) begin
            bad++; $display("FAIL fwd_none got=%h exp=1", dataa);
        end
        drive_op(32'h404, 5'd3, 5'd5, 5'd1, 32'd1, 32'h2, 32'h0, 1'b0, 2'b00, 4'h0, 1'b1);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'hAAAA;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'hCCCC;
        tick();
        total++;
        if (dataa !== 32'hAAAA || datab !== 32'hCCCC || out_store_data !== 32'hCCCC) begin
            bad++; $display("FAIL fwd_indep got=%h %h %h exp=aaaa cccc cccc", dataa, datab, out_store_data);
        end
        clear_fwd(); in_valid = 1'b0;
        tick();
        $display("test_fwd_priority: done");
    endtask

    task automatic test_x0();
        out_ready = 1'b1; in_valid = 1'b1;
        drive_op(32'h500, 5'd0, 5'd0, 5'd2, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b00, 4'h0, 1'b1);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'h1234;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h5678;
        tick();
        total++;
        if (datab !== 32'h0 || out_store_data !== 32'h0) begin
            bad++; $display("FAIL x0_rs2 got=%h %h exp=0 0", datab, out_store_data);
        end
        total++;
        if (dataa !== 32'h0) begin
            bad++; $display("FAIL x0_rs1 got=%h exp=0", dataa);
        end
        clear_fwd(); in_valid = 1'b0;
        tick();
        $display("test_x0: done");
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        drive_op(32'h600, 5'd1, 5'd2, 5'd3, 32'h10, 32'h0, 32'h0, 1'b0, 2'b11, 4'h0, 1'b1);
        tick();
        drive_op(32'h604, 5'd1, 5'd2, 5'd4, 32'h77, 32'h0, 32'h0, 1'b0, 2'b11, 4'h0, 1'b1);
        flush = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_valid got=%b exp=0", out_valid);
        end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || dataa === 32'h77) begin
            bad++; $display("FAIL flush_discard got=%b %h", out_valid, dataa);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        drive_op(32'h100, 5'd1, 5'd2, 5'd5, 32'h9, 32'h0, 32'h2000, 1'b1, 2'b01, 4'h0, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b1 || dataa !== 32'h100 || datab !== 32'h2000) begin
            bad++; $display("FAIL auipc got=%b %h %h exp=1 100 2000", out_valid, dataa, datab);
        end
        in_valid = 1'b0;
        tick();
        $display("test_flush: done");
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 1'b1;
        drive_op(32'h700, 5'd1, 5'd2, 5'd6, 32'h31, 32'h32, 32'h33, 1'b0, 2'b00, 4'h9, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL rst_stall_load got=%b exp=1", out_valid);
        end
        rst_n = 1'b0; flush = 1'b1;
        tick();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_regwr !== 1'b0) begin
            bad++; $display("FAIL rst_stall_ctl got=%b %b %b exp=0 1 0", out_valid, in_ready, out_regwr);
        end
        total++;
        if ({dataa, datab, out_store_data, out_pc, out_rd, ALUctr} !== 137'h0) begin
            bad++; $display("FAIL rst_stall_data got=%h %h %h %h %h %h", dataa, datab, out_store_data,
                            out_pc, out_rd, ALUctr);
        end
        $display("test_reset_mid_stall: done");
    endtask

    initial begin
        clear_fwd();
        test_reset();
        test_back_to_back();
        test_operand_mux();
        test_stall();
        test_fwd_priority();
        test_x0();
        test_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
